// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and constants for the unified memory arbiter.
// Holds the FSM state and owner encodings plus the fixed fetch width code.
package unified_mem_arbiter_pkg;

    localparam int unsigned AddrW = 8;
    localparam int unsigned DataW = 32;

    // Fetches are always full-word reads.
    localparam logic [2:0] FetchFun3 = 3'b010;

    typedef enum logic {
        StIdle,
        StWait
    } arb_state_e;

    typedef enum logic {
        OwnIf,
        OwnD
    } arb_owner_e;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Bundle of the fetch port, load/store port and memory-macro signals around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding datapath and memory.
interface unified_mem_arbiter_if;
    import unified_mem_arbiter_pkg::*;

    logic             if_req;
    logic [AddrW-1:0] if_addr;
    logic             if_gnt;
    logic             if_rvalid;
    logic [DataW-1:0] if_rdata;

    logic             d_req;
    logic             d_we;
    logic [2:0]       d_fun3;
    logic [AddrW-1:0] d_addr;
    logic [DataW-1:0] d_wdata;
    logic             d_gnt;
    logic             d_rvalid;
    logic [DataW-1:0] d_rdata;

    logic             mem_en;
    logic             mem_we;
    logic [2:0]       mem_fun3;
    logic [AddrW-1:0] mem_addr;
    logic [DataW-1:0] mem_wdata;
    logic [DataW-1:0] mem_rdata;

    logic             busy;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_fun3, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_fun3, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_fun3, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_fun3, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy
    );

endinterface

// File: rtl/unified_mem_arbiter_pick.sv
// Winner select between fetch and load/store: D has priority, but once D has been
// granted StarveMax times in a row over a waiting fetch, the fetch is forced through.
module unified_mem_arbiter_pick #(
    parameter int unsigned StarveMax = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic if_req_i,
    input  logic d_req_i,
    input  logic grant_en_i,
    output logic valid_o,
    output logic win_d_o
);

    localparam int unsigned CntW = $clog2(StarveMax + 1);

    logic [CntW-1:0] starve_q, starve_d;
    logic            starved;

    assign starved = (starve_q == CntW'(StarveMax));
    assign valid_o = if_req_i | d_req_i;
    assign win_d_o = d_req_i & ~(if_req_i & starved);

    always_comb begin
        starve_d = starve_q;
        if (!if_req_i) begin
            starve_d = '0;
        end else if (grant_en_i && valid_o) begin
            if (win_d_o) begin
                starve_d = starved ? starve_q : starve_q + CntW'(1);
            end else begin
                starve_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store, one access
// in flight at a time, with back-to-back grants on the completion cycle.
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int unsigned MemLat    = 1,
    parameter int unsigned StarveMax = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    unified_mem_arbiter_if.slave  bus_io
);

    localparam int unsigned LatW = (MemLat > 1) ? $clog2(MemLat) : 1;

    arb_state_e      state_q, state_d;
    arb_owner_e      owner_q, owner_d;
    logic            we_q, we_d;
    logic [LatW-1:0] lat_q, lat_d;

    logic complete;
    logic grant_slot;
    logic pick_valid;
    logic pick_d;
    logic granting;

    assign complete   = (state_q == StWait) && (lat_q == '0);
    // Reset gating keeps every output low while rst_ni is held, even with requests up.
    assign grant_slot = rst_ni && ((state_q == StIdle) || complete);
    assign granting   = grant_slot && pick_valid;

    unified_mem_arbiter_pick #(
        .StarveMax (StarveMax)
    ) u_pick (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .if_req_i   (bus_io.if_req),
        .d_req_i    (bus_io.d_req),
        .grant_en_i (grant_slot),
        .valid_o    (pick_valid),
        .win_d_o    (pick_d)
    );

    always_comb begin
        state_d          = state_q;
        owner_d          = owner_q;
        we_d             = we_q;
        lat_d            = lat_q;
        bus_io.if_gnt    = 1'b0;
        bus_io.if_rvalid = 1'b0;
        bus_io.if_rdata  = '0;
        bus_io.d_gnt     = 1'b0;
        bus_io.d_rvalid  = 1'b0;
        bus_io.d_rdata   = '0;
        bus_io.mem_en    = 1'b0;
        bus_io.mem_we    = 1'b0;
        bus_io.mem_fun3  = '0;
        bus_io.mem_addr  = '0;
        bus_io.mem_wdata = '0;

        if (complete) begin
            if (owner_q == OwnIf) begin
                bus_io.if_rvalid = 1'b1;
                bus_io.if_rdata  = bus_io.mem_rdata;
            end else begin
                bus_io.d_rvalid = 1'b1;
                bus_io.d_rdata  = we_q ? '0 : bus_io.mem_rdata;
            end
        end

        if (granting) begin
            bus_io.mem_en = 1'b1;
            state_d       = StWait;
            lat_d         = LatW'(MemLat - 1);
            if (pick_d) begin
                bus_io.d_gnt     = 1'b1;
                bus_io.mem_we    = bus_io.d_we;
                bus_io.mem_fun3  = bus_io.d_fun3;
                bus_io.mem_addr  = bus_io.d_addr;
                bus_io.mem_wdata = bus_io.d_wdata;
                owner_d          = OwnD;
                we_d             = bus_io.d_we;
            end else begin
                bus_io.if_gnt   = 1'b1;
                bus_io.mem_fun3 = FetchFun3;
                bus_io.mem_addr = bus_io.if_addr;
                owner_d         = OwnIf;
                we_d            = 1'b0;
            end
        end else if (complete) begin
            state_d = StIdle;
        end else if (state_q == StWait) begin
            lat_d = lat_q - LatW'(1);
        end

        bus_io.busy = (state_q == StWait) && !(complete && !granting);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            owner_q <= OwnIf;
            we_q    <= 1'b0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            lat_q   <= lat_d;
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: one instance at MemLat=1 for arbitration,
// starvation, store and reset cases, and one at MemLat=3 for back-to-back latency.
module tb_unified_mem_arbiter;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    unified_mem_arbiter_if a ();
    unified_mem_arbiter_if b ();

    unified_mem_arbiter #(
        .MemLat    (1),
        .StarveMax (4)
    ) u_dut_a (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus_io (a)
    );

    unified_mem_arbiter #(
        .MemLat    (3),
        .StarveMax (4)
    ) u_dut_b (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus_io (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h @%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Requests must hold their payload until granted.
    logic       pend_if, pend_d;
    logic [7:0] addr_if_q, addr_d_q;
    always @(posedge clk) begin
        if (!rst_n) begin
            pend_if <= 1'b0;
            pend_d  <= 1'b0;
        end else begin
            if (pend_if && a.if_req)
                assert (a.if_addr == addr_if_q) else $error("protocol: if_addr moved while pending");
            if (pend_d && a.d_req)
                assert (a.d_addr == addr_d_q) else $error("protocol: d_addr moved while pending");
            pend_if   <= a.if_req && !a.if_gnt;
            pend_d    <= a.d_req && !a.d_gnt;
            addr_if_q <= a.if_addr;
            addr_d_q  <= a.d_addr;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [5:0] starve_seq;
        n_cmp = 0;
        n_bad = 0;
        starve_seq = 6'b101111;  // bit k = expected d_gnt in cycle k
        rst_n = 1'b0;
        a.if_req = 0; a.if_addr = '0; a.d_req = 0; a.d_we = 0; a.d_fun3 = '0;
        a.d_addr = '0; a.d_wdata = '0; a.mem_rdata = '0;
        b.if_req = 0; b.if_addr = '0; b.d_req = 0; b.d_we = 0; b.d_fun3 = '0;
        b.d_addr = '0; b.d_wdata = '0; b.mem_rdata = '0;

        // Held in reset with a request pending: nothing may be granted.
        #2;
        a.if_req = 1; a.if_addr = 8'h44;
        #1;
        check_eq("rst_if_gnt", a.if_gnt, 0);
        check_eq("rst_mem_en", a.mem_en, 0);
        check_eq("rst_mem_addr", a.mem_addr, 0);
        check_eq("rst_busy", a.busy, 0);
        a.if_req = 0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // Fetch only, back-to-back.
        a.if_req = 1; a.if_addr = 8'h04; a.mem_rdata = 32'hA5A5_0001;
        #1;
        check_eq("f_gnt", a.if_gnt, 1);
        check_eq("f_mem_en", a.mem_en, 1);
        check_eq("f_mem_addr", a.mem_addr, 8'h04);
        check_eq("f_mem_fun3", a.mem_fun3, 3'b010);
        check_eq("f_mem_we", a.mem_we, 0);
        check_eq("f_rvalid_early", a.if_rvalid, 0);
        next_cycle();
        a.if_addr = 8'h08;
        #1;
        check_eq("f_rvalid", a.if_rvalid, 1);
        check_eq("f_rdata", a.if_rdata, 32'hA5A5_0001);
        check_eq("f_gnt2", a.if_gnt, 1);
        check_eq("f_mem_addr2", a.mem_addr, 8'h08);
        check_eq("f_busy", a.busy, 1);
        next_cycle();
        a.if_req = 0;
        #1;
        check_eq("f_rvalid2", a.if_rvalid, 1);
        check_eq("f_gnt_none", a.if_gnt, 0);
        check_eq("f_busy_last", a.busy, 0);
        check_eq("f_mem_en_idle", a.mem_en, 0);
        next_cycle();
        #1;
        check_eq("f_rvalid_idle", a.if_rvalid, 0);

        // Collision: D first, IF on the D completion cycle.
        next_cycle();
        a.if_req = 1; a.if_addr = 8'h0C;
        a.d_req = 1; a.d_we = 0; a.d_addr = 8'h20; a.d_fun3 = 3'b100;
        a.mem_rdata = 32'h0000_00C3;
        #1;
        check_eq("c_d_gnt", a.d_gnt, 1);
        check_eq("c_if_gnt", a.if_gnt, 0);
        check_eq("c_mem_addr", a.mem_addr, 8'h20);
        check_eq("c_mem_fun3", a.mem_fun3, 3'b100);
        next_cycle();
        a.d_req = 0;
        #1;
        check_eq("c_d_rvalid", a.d_rvalid, 1);
        check_eq("c_d_rdata", a.d_rdata, 32'h0000_00C3);
        check_eq("c_if_gnt2", a.if_gnt, 1);
        check_eq("c_mem_addr2", a.mem_addr, 8'h0C);
        check_eq("c_mem_fun3_2", a.mem_fun3, 3'b010);
        next_cycle();
        a.if_req = 0;
        #1;
        check_eq("c_if_rvalid", a.if_rvalid, 1);
        check_eq("c_if_rdata", a.if_rdata, 32'h0000_00C3);
        check_eq("c_d_rvalid_none", a.d_rvalid, 0);

        // Starvation: D,D,D,D,IF,D with both held.
        next_cycle();
        a.if_req = 1; a.if_addr = 8'h50;
        a.d_req = 1; a.d_addr = 8'h60; a.d_fun3 = 3'b010;
        for (int k = 0; k < 6; k++) begin
            #1;
            check_eq($sformatf("s_d_gnt%0d", k), a.d_gnt, starve_seq[k]);
            check_eq($sformatf("s_if_gnt%0d", k), a.if_gnt, !starve_seq[k]);
            check_eq($sformatf("s_if_rv%0d", k), a.if_rvalid, k == 5);
            check_eq($sformatf("s_d_rv%0d", k), a.d_rvalid, k >= 1 && k != 5);
            next_cycle();
        end
        a.if_req = 0; a.d_req = 0;
        #1;
        check_eq("s_d_rv_tail", a.d_rvalid, 1);
        check_eq("s_mem_en_tail", a.mem_en, 0);

        // Store.
        next_cycle();
        a.d_req = 1; a.d_we = 1; a.d_addr = 8'h10; a.d_wdata = 32'hDEAD_BEEF;
        a.d_fun3 = 3'b010; a.mem_rdata = 32'hFFFF_FFFF;
        #1;
        check_eq("st_gnt", a.d_gnt, 1);
        check_eq("st_mem_we", a.mem_we, 1);
        check_eq("st_mem_addr", a.mem_addr, 8'h10);
        check_eq("st_mem_wdata", a.mem_wdata, 32'hDEAD_BEEF);
        check_eq("st_mem_fun3", a.mem_fun3, 3'b010);
        next_cycle();
        a.d_req = 0; a.d_we = 0;
        #1;
        check_eq("st_rvalid", a.d_rvalid, 1);
        check_eq("st_rdata", a.d_rdata, 0);

        // Reset in the middle of a fetch.
        next_cycle();
        a.if_req = 1; a.if_addr = 8'h40;
        #1;
        check_eq("r_gnt", a.if_gnt, 1);
        next_cycle();
        a.if_req = 0;
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("r_if_rvalid", a.if_rvalid, 0);
        check_eq("r_busy", a.busy, 0);
        check_eq("r_mem_en", a.mem_en, 0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        #1;
        check_eq("r_post_rvalid", a.if_rvalid, 0);
        check_eq("r_post_busy", a.busy, 0);

        // MemLat=3 back-to-back loads.
        next_cycle();
        b.d_req = 1; b.d_we = 0; b.d_addr = 8'h30; b.d_fun3 = 3'b010;
        b.mem_rdata = 32'h0000_0B0B;
        for (int k = 0; k < 9; k++) begin
            #1;
            check_eq($sformatf("l_gnt%0d", k), b.d_gnt, (k % 3) == 0);
            check_eq($sformatf("l_en%0d", k), b.mem_en, (k % 3) == 0);
            check_eq($sformatf("l_rv%0d", k), b.d_rvalid, k >= 3 && (k % 3) == 0);
            check_eq($sformatf("l_busy%0d", k), b.busy, k >= 1);
            next_cycle();
        end
        b.d_req = 0;
        #1;
        check_eq("l_rv_tail", b.d_rvalid, 1);
        check_eq("l_rdata_tail", b.d_rdata, 32'h0000_0B0B);
        check_eq("l_busy_tail", b.busy, 0);
        check_eq("l_en_tail", b.mem_en, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
